adc_capture_pack: RTL and testbench

- Parametrised successor to the per-channel ADC DDR demux stage.
- Takes NCH channels of already-demultiplexed ADC samples, each carrying two samples per clk64 cycle.
- Applies a per-channel enable mask and a bit-depth reduction mode, then bit-packs the selected samples LSB-first into OW-bit words.
- Buffers words in a first-word-fall-through FIFO with a valid/ready output toward the packet framer, and counts dropped words on overflow.

---
 rtl/adc_capture_pkg.sv | 30 +++
 rtl/adc_capture_pack_fifo.sv | 53 +++++
 rtl/adc_capture_pack.sv | 214 +++++++++++++++++++++
 tb/tb_adc_capture_pack.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared encodings for the ADC capture/pack path.
// Mode codes, FSM states and the header magic byte.
package adc_capture_pkg;

   localparam logic [1:0] MODE_FULL = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_2BIT = 2'b10;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HDR   = 2'd3
   } state_t;

   // Kept bits per sample; unknown modes fall back to full width.
   function automatic int red_width(
      input logic [1:0] mode,
      input int         sw
   );
      unique case (1'b1)
         (mode == MODE_HALF): return sw / 2;
         (mode == MODE_2BIT): return 2;
         default:             return sw;
      endcase
   endfunction

endpackage

// File: rtl/adc_capture_pack_fifo.sv
// First-word-fall-through synchronous FIFO.
// A push into a full FIFO succeeds when a pop frees a slot.
module sync_fifo_fwft #(
   parameter int W     = 64,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd;
   logic [AW-1:0] wr;
   logic          do_pop;
   logic          do_push;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop)  rd <= rd + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (nreset && do_push) mem[wr] <= push_data;
   end

endmodule

// File: rtl/adc_capture_pack.sv
// Channel mask, bit-depth reduction and LSB-first word packing.
// ADC_CAPTURE_PACK_TAG_EN adds a timestamped header word per run.
module adc_capture_pack
   import adc_capture_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int SW    = 8,
   parameter int OW    = 64,
   parameter int DEPTH = 16,
   parameter int CW    = 16
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              enable,
   input  logic [NCH-1:0]    ch_mask,
   input  logic [1:0]        mode,
   input  logic [NCH*2*SW-1:0] x,
   output logic [OW-1:0]     out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              overflow,
   output logic [CW-1:0]     ovf_count
);

   localparam int FW = $clog2(2 * OW);
   localparam int AW = $clog2(DEPTH);

   state_t          state;
   logic [NCH-1:0]  mask_q;
   logic [1:0]      mode_q;

   logic [FW-1:0]   bw;
   logic [SW-1:0]   smp;
   logic [SW-1:0]   fld;
   logic [OW-1:0]   pack_c;
   logic [FW-1:0]   k_c;

   logic            v1;
   logic [OW-1:0]   pack1;
   logic [FW-1:0]   k1;

   logic [2*OW-1:0] acc;
   logic [2*OW-1:0] acc_sum;
   logic [FW-1:0]   fill;
   logic [FW-1:0]   fill_sum;
   logic            word_v;
   logic [OW-1:0]   word;

   logic            pop;
   logic            drop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [AW:0]     fifo_count_unused;
   logic            start;

`ifdef ADC_CAPTURE_PACK_TAG_EN
   logic [31:0]     cyc;
   logic [OW-1:0]   hdr_word;

   assign hdr_word = OW'({HDR_MAGIC, 6'b0, mode_q,
                          8'(mask_q), cyc});

   // Free-running timestamp, restarted only by reset.
   always_ff @(posedge clk) begin
      if (!nreset) cyc <= '0;
      else         cyc <= cyc + 32'd1;
   end
`endif

   assign start     = (state == ST_IDLE) && enable;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign drop      = word_v && fifo_full && !pop;

   // Run control; mask and mode are frozen for the whole run.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         mask_q <= '0;
         mode_q <= MODE_FULL;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (enable) begin
                  mask_q <= ch_mask;
                  mode_q <= mode;
                  busy   <= 1'b1;
`ifdef ADC_CAPTURE_PACK_TAG_EN
                  state  <= ST_HDR;
`else
                  state  <= ST_RUN;
`endif
               end
            end
            ST_HDR: state <= ST_RUN;
            ST_RUN: begin
               if (!enable) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Kept bits per sample for the latched mode.
   always_comb begin
      bw = FW'(red_width(mode_q, SW));
   end

   // Gather earlier samples, then later ones, keeping the MSBs.
   always_comb begin
      pack_c = '0;
      k_c    = '0;
      smp    = '0;
      fld    = '0;
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < NCH; c++) begin
            if (mask_q[c]) begin
               smp    = x[c*2*SW + s*SW +: SW];
               fld    = smp >> (FW'(SW) - bw);
               pack_c = pack_c |
                        ({{(OW-SW){1'b0}}, fld} << k_c);
               k_c    = k_c + bw;
            end
         end
      end
   end

   // Input register stage holding one cycle's packed bits.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         v1    <= 1'b0;
         pack1 <= '0;
         k1    <= '0;
      end else begin
         v1    <= (state == ST_RUN) && enable;
         pack1 <= pack_c;
         k1    <= k_c;
      end
   end

   assign acc_sum  = acc | ({{OW{1'b0}}, pack1} << fill);
   assign fill_sum = fill + k1;

   // Accumulate the bit stream and cut it into OW-bit words.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         acc    <= '0;
         fill   <= '0;
         word   <= '0;
         word_v <= 1'b0;
      end else begin
         word_v <= 1'b0;
         if (v1) begin
            if (fill_sum >= FW'(OW)) begin
               word   <= acc_sum[OW-1:0];
               word_v <= 1'b1;
               acc    <= acc_sum >> OW;
               fill   <= fill_sum - FW'(OW);
            end else begin
               acc  <= acc_sum;
               fill <= fill_sum;
            end
         end else if (state == ST_DRAIN) begin
            if (fill != '0) begin
               word   <= acc[OW-1:0];
               word_v <= 1'b1;
            end
            acc  <= '0;
            fill <= '0;
         end
`ifdef ADC_CAPTURE_PACK_TAG_EN
         else if (state == ST_HDR) begin
            word   <= hdr_word;
            word_v <= 1'b1;
         end
`endif
      end
   end

   // Sticky drop flag and saturating drop count for this run.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         overflow  <= 1'b0;
         ovf_count <= '0;
      end else if (start) begin
         overflow  <= 1'b0;
         ovf_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
      end
   end

   sync_fifo_fwft #(
      .W     (OW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .nreset    (nreset),
      .push      (word_v),
      .push_data (word),
      .pop       (pop),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused)
   );

endmodule

// File: tb/tb_adc_capture_pack.sv
// Bench for adc_capture_pack: bit-stream reference model,
// scoreboard of expected words and directed scenarios.
module tb_adc_capture_pack;

   localparam int NCH   = 4;
   localparam int SW    = 8;
   localparam int OW    = 64;
   localparam int DEPTH = 16;
   localparam int CW    = 16;
`ifdef ADC_CAPTURE_PACK_TAG_EN
   localparam int LAT   = 2;
`else
   localparam int LAT   = 3;
`endif

   logic            clk = 1'b0;
   logic            nreset = 1'b0;
   logic            enable = 1'b0;
   logic [NCH-1:0]  ch_mask = '0;
   logic [1:0]      mode = 2'b00;
   logic [63:0]     x = '0;
   logic [OW-1:0]   out_data;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic            busy;
   logic            overflow;
   logic [CW-1:0]   ovf_count;

   int              checks = 0;
   int              errors = 0;
   logic [63:0]     exp_q[$];
   logic [63:0]     model_q[$];
   logic [31:0]     tb_cnt = '0;
   logic [31:0]     run_t0 = '0;
   logic [31:0]     first_t = '0;
   bit              seen_first = 1'b0;
   int              d;

   adc_capture_pack #(
      .NCH(NCH), .SW(SW), .OW(OW), .DEPTH(DEPTH), .CW(CW)
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .enable    (enable),
      .ch_mask   (ch_mask),
      .mode      (mode),
      .x         (x),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .overflow  (overflow),
      .ovf_count (ovf_count)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) tb_cnt <= nreset ? tb_cnt + 1 : 32'd0;

   function automatic logic [63:0] gen_x(input int sel, input int j);
      case (sel)
         0: return 64'h0123456789ABCDEF;
         1: return {48'hFFFF_FFFF_FFFF, 16'hC040};
         2: return 64'hF0E1D2C3B4A59687 +
                   64'(j) * 64'h0101010101010101;
         default: return 64'h0011223344556677 ^
                   (64'(j) * 64'h13579BDF2468ACE1);
      endcase
   endfunction

   // Serialise every kept field into one bit queue, then cut words.
   task automatic model(input logic [3:0] m, input logic [1:0] md,
                        input int n, input int sel);
      bit          bq[$];
      logic [63:0] xv;
      logic [63:0] w;
      logic [7:0]  smp;
      int          b;
      int          i;
      model_q.delete();
      b = (md == 2'b01) ? 4 : (md == 2'b10) ? 2 : 8;
      for (int j = 0; j < n; j++) begin
         xv = gen_x(sel, j);
         for (int s = 0; s < 2; s++)
            for (int c = 0; c < NCH; c++)
               if (m[c]) begin
                  smp = xv[c*16 + s*8 +: 8];
                  for (int k = 0; k < b; k++)
                     bq.push_back(smp[8-b+k]);
               end
         while (bq.size() >= 64) begin
            w = '0;
            for (int k = 0; k < 64; k++) w[k] = bq.pop_front();
            model_q.push_back(w);
         end
      end
      if (bq.size() > 0) begin
         w = '0;
         i = 0;
         while (bq.size() > 0) begin
            w[i] = bq.pop_front();
            i++;
         end
         model_q.push_back(w);
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic run(input logic [3:0] m, input logic [1:0] md,
                      input int n, input int sel, input int keep,
                      output int dropped);
      logic [63:0] all[$];
      model(m, md, n, sel);
      ch_mask = m;
      mode    = md;
      enable  = 1'b1;
      @(posedge clk); #1;
      run_t0     = tb_cnt;
      seen_first = 1'b0;
      all.delete();
`ifdef ADC_CAPTURE_PACK_TAG_EN
      all.push_back({8'h00, 8'hA5, 6'b0, md, 4'b0, m, tb_cnt});
      @(posedge clk); #1;
`endif
      foreach (model_q[i]) all.push_back(model_q[i]);
      dropped = 0;
      foreach (all[i]) begin
         if (keep < 0 || i < keep) exp_q.push_back(all[i]);
         else dropped++;
      end
      for (int j = 0; j < n; j++) begin
         x = gen_x(sel, j);
         @(posedge clk); #1;
      end
      enable = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_drain(input string nm);
      int c = 0;
      while ((exp_q.size() != 0 || out_valid) && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      chk(nm, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      fork
         forever begin
            logic [63:0] w;
            @(negedge clk);
            if (nreset && out_valid && out_ready) begin
               if (!seen_first) begin
                  first_t    = tb_cnt;
                  seen_first = 1'b1;
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL word_extra got=%h want=none",
                           out_data);
               end else begin
                  w = exp_q.pop_front();
                  if (out_data !== w) begin
                     errors++;
                     $display("FAIL word got=%h want=%h",
                              out_data, w);
                  end
               end
            end
         end
      join_none

      // Reset state
      repeat (2) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_ovf_count", 64'(ovf_count), 64'd0);
      @(posedge clk); #1;
      nreset = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end

      // Full depth, all channels, constant input
      run(4'hF, 2'b00, 4, 0, -1, d);
      chk("t1_pin", model_q[0], 64'h014589CD2367ABEF);
      chk("t1_latency", 64'(first_t - run_t0), 64'(LAT));
      wait_drain("t1_drain");

      // 2-bit mode, channel 0 only
      run(4'b0001, 2'b10, 16, 1, -1, d);
      chk("t2_pin", model_q[0], 64'hDDDDDDDDDDDDDDDD);
      chk("t2_count", 64'(model_q.size()), 64'd1);
      wait_drain("t2_drain");

      // Three channels: straddling words and a padded drain word
      run(4'b0111, 2'b00, 5, 2, -1, d);
      chk("t3_count", 64'(model_q.size()), 64'd4);
      chk("t3_pad", 64'(model_q[3][63:48]), 64'd0);
      wait_drain("t3_drain");

      // Empty mask still runs and drains without output
      run(4'b0000, 2'b01, 3, 3, -1, d);
      chk("t4_count", 64'(model_q.size()), 64'd0);
      chk("t4_busy", 64'(busy), 64'd0);
      wait_drain("t4_drain");

      // Overflow with a stalled consumer
      out_ready = 1'b0;
      run(4'hF, 2'b00, 20, 3, DEPTH, d);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("t5_valid", 64'(out_valid), 64'd1);
      chk("t5_ovf", 64'(overflow), 64'd1);
      chk("t5_ovf_count", 64'(ovf_count), 64'(d));
      chk("t5_busy", 64'(busy), 64'd0);
      out_ready = 1'b1;
      wait_drain("t5_drain");

      // Reset in the middle of a run
      out_ready = 1'b0;
      ch_mask   = 4'hF;
      mode      = 2'b00;
      x         = gen_x(0, 0);
      enable    = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("t6_busy_pre", 64'(busy), 64'd1);
      chk("t6_valid_pre", 64'(out_valid), 64'd1);
      nreset = 1'b0;
      enable = 1'b0;
      @(posedge clk); #1;
      nreset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_ovf_count", 64'(ovf_count), 64'd0);
      chk("t6_ovf", 64'(overflow), 64'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      run(4'hF, 2'b00, 4, 0, -1, d);
      chk("t6_pin", model_q[0], 64'h014589CD2367ABEF);
      chk("t6_latency", 64'(first_t - run_t0), 64'(LAT));
      wait_drain("t6_drain");

`ifdef ADC_CAPTURE_PACK_TAG_EN
      // Header ahead of half-depth data
      run(4'b0101, 2'b01, 6, 3, -1, d);
      wait_drain("t7_drain");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
